// File: rtl/switch_v2_top.sv
// switch_v2_top
// Single-ingress packet switch with NUM_OF_PORTS egress FIFOs and an
// integrated register file.
//
// Packet format on data_in: DA, SA, LEN, then LEN payload words. The route
// mask is computed from DA against PORT_ADDR[i]. With CTRL.bcast_en set,
// BCAST_ADDR selects every port. The mask is latched on the DA transfer and
// held for the rest of the packet. Every transferred word is pushed into all
// masked FIFOs in the same cycle. A packet whose mask is zero is consumed
// without writes, and DROP_CNT counts it.
//
// Handshake: a word transfers in a cycle where sw_enable_in && in_ready.
// in_ready is combinational and never depends on sw_enable_in. A FIFO pops
// in a cycle where port_read[i] && port_ready[i].
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sw_enable_in        ingress word valid
//   data_in             ingress word
//   in_ready            switch can accept data_in this cycle
//   port_read           per-port pop request
//   port_out            per-port FIFO head, port i at [i*WORD_WIDTH +: WORD_WIDTH]
//   port_ready          per-port FIFO not empty
//   mem_sel_en          register access strobe
//   mem_wr_rd_s         1 = write, 0 = read
//   mem_addr            register address
//   mem_wr_data         write data
//   mem_rd_data         registered read data, valid while mem_ack=1
//   mem_ack             one-cycle acknowledge, the cycle after the strobe
//   dbg_state           current packet FSM state (0=DA,1=SA,2=LEN,3=PAY)
module switch_v2_top #(
    parameter int NUM_OF_PORTS = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int WORD_WIDTH   = 8,
    parameter logic [WORD_WIDTH-1:0] BCAST_ADDR = {WORD_WIDTH{1'b1}}
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               sw_enable_in,
    input  logic [WORD_WIDTH-1:0]              data_in,
    output logic                               in_ready,
    input  logic [NUM_OF_PORTS-1:0]            port_read,
    output logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
    output logic [NUM_OF_PORTS-1:0]            port_ready,
    input  logic                               mem_sel_en,
    input  logic                               mem_wr_rd_s,
    input  logic [WORD_WIDTH-1:0]              mem_addr,
    input  logic [WORD_WIDTH-1:0]              mem_wr_data,
    output logic [WORD_WIDTH-1:0]              mem_rd_data,
    output logic                               mem_ack,
    output logic [1:0]                         dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WORD_WIDTH-1:0] CTRL_ADDR = WORD_WIDTH'(NUM_OF_PORTS);
    localparam logic [WORD_WIDTH-1:0] DROP_ADDR = WORD_WIDTH'(NUM_OF_PORTS + 1);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_DA = 2'd0, S_SA = 2'd1, S_LEN = 2'd2, S_PAY = 2'd3} state_e;

    // Packet FSM
    state_e                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   len_q, len_d;
    logic [NUM_OF_PORTS-1:0] mask_q, mask_d;

    // Register file
    logic [WORD_WIDTH-1:0]   port_addr_q [NUM_OF_PORTS];
    logic [WORD_WIDTH-1:0]   port_addr_d [NUM_OF_PORTS];
    logic                    bcast_en_q, bcast_en_d;
    logic [WORD_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic                    ack_q, ack_d;
    logic [WORD_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [WORD_WIDTH-1:0]   reg_rd_val;

    // Egress FIFOs
    logic [PTR_W-1:0]        wr_ptr_q [NUM_OF_PORTS];
    logic [PTR_W-1:0]        wr_ptr_d [NUM_OF_PORTS];
    logic [PTR_W-1:0]        rd_ptr_q [NUM_OF_PORTS];
    logic [PTR_W-1:0]        rd_ptr_d [NUM_OF_PORTS];
    logic [CNT_W-1:0]        cnt_q    [NUM_OF_PORTS];
    logic [CNT_W-1:0]        cnt_d    [NUM_OF_PORTS];
    logic [WORD_WIDTH-1:0]   fifo_mem_q [NUM_OF_PORTS][FIFO_DEPTH];

    logic [NUM_OF_PORTS-1:0] da_mask;
    logic [NUM_OF_PORTS-1:0] active_mask;
    logic [NUM_OF_PORTS-1:0] full;
    logic [NUM_OF_PORTS-1:0] empty;
    logic [NUM_OF_PORTS-1:0] push;
    logic [NUM_OF_PORTS-1:0] pop;
    logic                    xfer;
    logic                    drop_inc;

    // Route mask for the word currently on data_in, treated as a DA.
    always_comb begin
        da_mask = '0;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            da_mask[i] = (data_in == port_addr_q[i]);
        end
        if (bcast_en_q && (data_in == BCAST_ADDR)) begin
            da_mask = '1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            full[i]  = (cnt_q[i] == FULL_CNT);
            empty[i] = (cnt_q[i] == '0);
        end
    end

    // A zero mask leaves in_ready high, so unmatched packets drain freely.
    // A full FIFO blocks ingress even if it pops in the same cycle.
    assign in_ready = &(~(active_mask & full));
    assign xfer     = sw_enable_in & in_ready;
    assign push     = xfer ? active_mask : '0;
    assign pop      = port_read & ~empty;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DA;
            len_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mask_q  <= mask_d;
        end
    end

    // FSM: next state, advancing only on a transfer
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mask_d  = mask_q;
        if (xfer) begin
            case (state_q)
                S_DA: begin
                    mask_d  = da_mask;
                    state_d = S_SA;
                end
                S_SA: state_d = S_LEN;
                S_LEN: begin
                    len_d   = data_in;
                    state_d = (data_in == '0) ? S_DA : S_PAY;
                end
                S_PAY: begin
                    len_d = len_q - 1'b1;
                    if (len_q == WORD_WIDTH'(1)) begin
                        state_d = S_DA;
                    end
                end
                default: state_d = S_DA;
            endcase
        end
    end

    // FSM: outputs. During DA the live mask applies, afterwards the latched one.
    always_comb begin
        active_mask = (state_q == S_DA) ? da_mask : mask_q;
        drop_inc    = (state_q == S_DA) && xfer && (da_mask == '0);
        dbg_state   = state_q;
    end

    // Register file
    always_comb begin
        reg_rd_val = '0;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            if (mem_addr == WORD_WIDTH'(i)) begin
                reg_rd_val = port_addr_q[i];
            end
        end
        if (mem_addr == CTRL_ADDR) begin
            reg_rd_val = {{(WORD_WIDTH-1){1'b0}}, bcast_en_q};
        end
        if (mem_addr == DROP_ADDR) begin
            reg_rd_val = drop_cnt_q;
        end
    end

    always_comb begin
        port_addr_d = port_addr_q;
        bcast_en_d  = bcast_en_q;
        drop_cnt_d  = drop_cnt_q;
        ack_d       = mem_sel_en;
        rd_data_d   = rd_data_q;
        if (mem_sel_en) begin
            if (mem_wr_rd_s) begin
                for (int i = 0; i < NUM_OF_PORTS; i++) begin
                    if (mem_addr == WORD_WIDTH'(i)) begin
                        port_addr_d[i] = mem_wr_data;
                    end
                end
                if (mem_addr == CTRL_ADDR) begin
                    bcast_en_d = mem_wr_data[0];
                end
                if (mem_addr == DROP_ADDR) begin
                    drop_cnt_d = '0;
                end
            end else begin
                rd_data_d = reg_rd_val;
            end
        end
        // The increment is applied after any clear, so a colliding clear gives 1.
        if (drop_inc && (drop_cnt_d != '1)) begin
            drop_cnt_d = drop_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OF_PORTS; i++) begin
                port_addr_q[i] <= WORD_WIDTH'(i);
            end
            bcast_en_q <= 1'b0;
            drop_cnt_q <= '0;
            ack_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            port_addr_q <= port_addr_d;
            bcast_en_q  <= bcast_en_d;
            drop_cnt_q  <= drop_cnt_d;
            ack_q       <= ack_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mem_ack     = ack_q;
    assign mem_rd_data = rd_data_q;

    // Egress FIFO bookkeeping
    always_comb begin
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OF_PORTS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the counters alone define what is visible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            if (push[i]) begin
                fifo_mem_q[i][wr_ptr_q[i]] <= data_in;
            end
        end
    end

    // First-word-fall-through head, forced to zero while empty.
    always_comb begin
        port_out = '0;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            port_out[i*WORD_WIDTH +: WORD_WIDTH] = empty[i] ? '0 : fifo_mem_q[i][rd_ptr_q[i]];
        end
    end

    assign port_ready = ~empty;

endmodule

// File: tb/tb_switch_v2_top.sv
module tb_switch_v2_top;
    localparam int NP    = 4;
    localparam int DEPTH = 16;
    localparam int W     = 8;
    localparam logic [W-1:0] CTRL_A = 8'(NP);
    localparam logic [W-1:0] DROP_A = 8'(NP + 1);

    typedef logic [W-1:0] wq_t[$];

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              sw_enable_in = 1'b0;
    logic [W-1:0]      data_in = '0;
    logic              in_ready;
    logic [NP-1:0]     port_read = '0;
    logic [NP*W-1:0]   port_out;
    logic [NP-1:0]     port_ready;
    logic              mem_sel_en = 1'b0;
    logic              mem_wr_rd_s = 1'b0;
    logic [W-1:0]      mem_addr = '0;
    logic [W-1:0]      mem_wr_data = '0;
    logic [W-1:0]      mem_rd_data;
    logic              mem_ack;
    logic [1:0]        dbg_state;

    switch_v2_top #(.NUM_OF_PORTS(NP), .FIFO_DEPTH(DEPTH), .WORD_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .sw_enable_in(sw_enable_in), .data_in(data_in), .in_ready(in_ready),
        .port_read(port_read), .port_out(port_out), .port_ready(port_ready),
        .mem_sel_en(mem_sel_en), .mem_wr_rd_s(mem_wr_rd_s), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
        .dbg_state(dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0]  exp_q[NP][$];
    logic [W-1:0]  m_port_addr[NP];
    logic          m_bcast;
    logic [W-1:0]  m_drop;
    int            m_pos;      // words of current packet consumed (0 = expecting DA)
    int            m_left;     // payload words still to come
    logic [NP-1:0] m_mask;
    logic          m_ack;
    logic          m_rd_chk;
    logic [W-1:0]  m_rd;

    function automatic logic [NP-1:0] model_mask(logic [W-1:0] da);
        logic [NP-1:0] m;
        for (int p = 0; p < NP; p++) m[p] = (da == m_port_addr[p]);
        if (m_bcast && da == 8'hFF) m = '1;
        return m;
    endfunction

    function automatic logic model_accepts(logic [NP-1:0] m);
        for (int p = 0; p < NP; p++)
            if (m[p] && exp_q[p].size() >= DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] model_reg(logic [W-1:0] a);
        if (int'(a) < NP) return m_port_addr[int'(a)];
        if (int'(a) == NP) return {7'd0, m_bcast};
        if (int'(a) == NP + 1) return m_drop;
        return '0;
    endfunction

    function automatic logic [W-1:0] exp_out(int p);
        return (exp_q[p].size() != 0) ? exp_q[p][0] : '0;
    endfunction

    function automatic logic [NP-1:0] exp_ready();
        logic [NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p] = (exp_q[p].size() != 0);
        return v;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            exp_q[p].delete();
            m_port_addr[p] = 8'(p);
        end
        m_bcast = 1'b0; m_drop = '0; m_pos = 0; m_left = 0; m_mask = '0;
        m_ack = 1'b0; m_rd_chk = 1'b0; m_rd = '0;
    endtask

    // ---------------- driver tasks ----------------
    // One clock: entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [W-1:0] w, input logic [NP-1:0] rd,
                         input logic sel, input logic wr, input logic [W-1:0] a,
                         input logic [W-1:0] wd, output logic ir_o, output logic ir_e);
        logic [NP-1:0] msk;
        logic [W-1:0]  rv;
        logic          inc, clr;
        sw_enable_in = v; data_in = w; port_read = rd;
        mem_sel_en = sel; mem_wr_rd_s = wr; mem_addr = a; mem_wr_data = wd;
        #2;
        ir_o = in_ready;
        msk  = (m_pos == 0) ? model_mask(w) : m_mask;
        ir_e = model_accepts(msk);
        rv   = model_reg(a);
        @(posedge clk);
        for (int p = 0; p < NP; p++)
            if (rd[p] && exp_q[p].size() != 0) void'(exp_q[p].pop_front());
        inc = 1'b0;
        if (v && ir_e) begin
            if (m_pos == 0) begin
                m_mask = msk;
                inc = (msk == '0);
            end
            for (int p = 0; p < NP; p++) if (msk[p]) exp_q[p].push_back(w);
            if (m_pos == 0) m_pos = 1;
            else if (m_pos == 1) m_pos = 2;
            else if (m_pos == 2) begin m_left = int'(w); m_pos = (w == 0) ? 0 : 3; end
            else begin m_left--; if (m_left == 0) m_pos = 0; end
        end
        clr = 1'b0;
        if (sel && wr) begin
            if (int'(a) < NP) m_port_addr[int'(a)] = wd;
            else if (int'(a) == NP) m_bcast = wd[0];
            else if (int'(a) == NP + 1) clr = 1'b1;
        end
        if (clr) m_drop = '0;
        if (inc && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        m_ack = sel;
        m_rd_chk = sel && !wr;
        if (sel && !wr) m_rd = rv;
        #1;
    endtask

    task automatic idle(input int n);
        logic io, ie;
        repeat (n) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, io, ie);
    endtask

    task automatic reg_wr(input logic [W-1:0] a, input logic [W-1:0] d);
        logic io, ie;
        cycle(1'b0, '0, '0, 1'b1, 1'b1, a, d, io, ie);
    endtask

    task automatic reg_rd(input logic [W-1:0] a);
        logic io, ie;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, a, '0, io, ie);
    endtask

    // Sends a whole packet, each word bounded by a cycle budget.
    task automatic send_pkt(input wq_t pkt, output int timeouts);
        logic io, ie;
        timeouts = 0;
        foreach (pkt[k]) begin
            int c = 0;
            do begin
                cycle(1'b1, pkt[k], '0, 1'b0, 1'b0, '0, '0, io, ie);
                c++;
            end while (!ie && c < 100);
            if (!ie) timeouts++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sw_enable_in = 1'b0; data_in = '0; port_read = '0;
        mem_sel_en = 1'b0; mem_wr_rd_s = 1'b0; mem_addr = '0; mem_wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (port_ready !== 4'b0000) begin n_err++; $display("FAIL reset_port_ready: got %b exp 0000", port_ready); end
        n_cmp++; if (port_out !== 32'h0) begin n_err++; $display("FAIL reset_port_out: got %h exp 0", port_out); end
        n_cmp++; if (mem_ack !== 1'b0) begin n_err++; $display("FAIL reset_mem_ack: got %b exp 0", mem_ack); end
        n_cmp++; if (mem_rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h exp 00", mem_rd_data); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    endtask

    task automatic test_regs();
        logic [W-1:0] exp_v;
        for (int a = 0; a <= NP + 1; a++) begin
            reg_rd(8'(a));
            exp_v = (a < NP) ? 8'(a) : 8'h00;
            n_cmp++; if (mem_ack !== 1'b1) begin n_err++; $display("FAIL reg_ack a%0d: got %b exp 1", a, mem_ack); end
            n_cmp++; if (mem_rd_data !== exp_v) begin n_err++; $display("FAIL reg_rd a%0d: got %h exp %h", a, mem_rd_data, exp_v); end
            idle(1);
            n_cmp++; if (mem_ack !== 1'b0) begin n_err++; $display("FAIL reg_ack_pulse a%0d: got %b exp 0", a, mem_ack); end
        end
        // back-to-back strobes
        reg_rd(8'd3);
        reg_rd(8'd1);
        n_cmp++; if (mem_ack !== 1'b1 || mem_rd_data !== 8'h01) begin n_err++; $display("FAIL reg_b2b: got ack %b data %h exp 1 01", mem_ack, mem_rd_data); end
        // unmapped address: acked, reads 0
        reg_wr(8'h80, 8'h5A);
        n_cmp++; if (mem_ack !== 1'b1) begin n_err++; $display("FAIL reg_unmapped_ack: got %b exp 1", mem_ack); end
        reg_rd(8'h80);
        n_cmp++; if (mem_rd_data !== 8'h00) begin n_err++; $display("FAIL reg_unmapped_rd: got %h exp 00", mem_rd_data); end
        // CTRL keeps only bit 0
        reg_wr(CTRL_A, 8'hFF);
        reg_rd(CTRL_A);
        n_cmp++; if (mem_rd_data !== 8'h01) begin n_err++; $display("FAIL reg_ctrl: got %h exp 01", mem_rd_data); end
        reg_wr(CTRL_A, 8'h00);
        idle(1);
    endtask

    task automatic test_unicast();
        wq_t pkt, e;
        int to;
        reg_wr(8'd2, 8'h55);
        pkt = {8'h55, 8'h01, 8'h03, 8'hA0, 8'hA1, 8'hA2};
        e = pkt;
        send_pkt(pkt, to);
        n_cmp++; if (to != 0) begin n_err++; $display("FAIL uni_timeout: got %0d exp 0", to); end
        idle(1);
        n_cmp++; if (port_ready !== 4'b0100) begin n_err++; $display("FAIL uni_ready: got %b exp 0100", port_ready); end
        foreach (e[k]) begin
            n_cmp++; if (port_out[2*W +: W] !== e[k] || port_ready[2] !== 1'b1) begin n_err++; $display("FAIL uni_pop%0d: got %h exp %h", k, port_out[2*W +: W], e[k]); end
            n_cmp++; if ((port_ready & 4'b1011) !== 4'b0000) begin n_err++; $display("FAIL uni_others: got %b exp 0000", port_ready & 4'b1011); end
            begin logic io, ie; cycle(1'b0, '0, 4'b0100, 1'b0, 1'b0, '0, '0, io, ie); end
        end
        n_cmp++; if (port_ready !== 4'b0000) begin n_err++; $display("FAIL uni_empty: got %b exp 0000", port_ready); end
    endtask

    task automatic test_bcast();
        wq_t pkt, e;
        int to;
        logic io, ie;
        reg_wr(CTRL_A, 8'h01);
        pkt = {8'hFF, 8'h12, 8'h00};
        e = pkt;
        send_pkt(pkt, to);
        idle(1);
        n_cmp++; if (port_ready !== 4'b1111 || to != 0) begin n_err++; $display("FAIL bc_ready: got %b (to %0d) exp 1111", port_ready, to); end
        foreach (e[k]) begin
            for (int p = 0; p < NP; p++) begin
                n_cmp++; if (port_out[p*W +: W] !== e[k]) begin n_err++; $display("FAIL bc_p%0d_w%0d: got %h exp %h", p, k, port_out[p*W +: W], e[k]); end
            end
            cycle(1'b0, '0, 4'b1111, 1'b0, 1'b0, '0, '0, io, ie);
        end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL bc_state: got %0d exp 0", dbg_state); end
        reg_wr(CTRL_A, 8'h00);
        send_pkt(pkt, to);
        idle(1);
        n_cmp++; if (port_ready !== 4'b0000) begin n_err++; $display("FAIL bc_off_ready: got %b exp 0000", port_ready); end
        reg_rd(DROP_A);
        n_cmp++; if (mem_rd_data !== 8'h01) begin n_err++; $display("FAIL bc_off_drop: got %h exp 01", mem_rd_data); end
        reg_wr(DROP_A, 8'h00);
    endtask

    task automatic test_backpressure();
        wq_t pkt;
        int acc = 0, dut_acc = 0, popped = 0;
        logic io, ie, v;
        logic [NP-1:0] rd;
        pkt = {8'h01, 8'h33, 8'd20};
        for (int k = 0; k < 20; k++) pkt.push_back(8'hC0 + 8'(k));
        for (int c = 0; c < 30; c++) begin
            cycle(1'b1, pkt[acc], '0, 1'b0, 1'b0, '0, '0, io, ie);
            if (io) dut_acc++;
            if (ie) acc++;
        end
        n_cmp++; if (dut_acc != 16) begin n_err++; $display("FAIL bp_fill: got %0d accepted exp 16", dut_acc); end
        n_cmp++; if (io !== 1'b0) begin n_err++; $display("FAIL bp_stall: got in_ready %b exp 0", io); end
        for (int c = 0; c < 100 && popped < 23; c++) begin
            rd = '0;
            if (exp_q[1].size() != 0) begin
                n_cmp++; if (port_out[1*W +: W] !== pkt[popped]) begin n_err++; $display("FAIL bp_order%0d: got %h exp %h", popped, port_out[1*W +: W], pkt[popped]); end
                rd = 4'b0010;
            end
            v = (acc < 23);
            cycle(v, v ? pkt[acc] : 8'h00, rd, 1'b0, 1'b0, '0, '0, io, ie);
            if (v && io) dut_acc++;
            if (v && ie) acc++;
            if (rd != 0) popped++;
        end
        n_cmp++; if (dut_acc != 23) begin n_err++; $display("FAIL bp_total: got %0d accepted exp 23", dut_acc); end
        n_cmp++; if (popped != 23 || port_ready !== 4'b0000) begin n_err++; $display("FAIL bp_drain: got %0d popped ready %b exp 23 0000", popped, port_ready); end
    endtask

    task automatic test_drop();
        wq_t pkt, e;
        int to;
        logic io, ie;
        pkt = {8'h77, 8'h01, 8'h02, 8'hB0, 8'hB1};
        foreach (pkt[k]) begin
            cycle(1'b1, pkt[k], '0, 1'b0, 1'b0, '0, '0, io, ie);
            n_cmp++; if (io !== 1'b1) begin n_err++; $display("FAIL drop_ready%0d: got %b exp 1", k, io); end
        end
        idle(1);
        n_cmp++; if (port_ready !== 4'b0000) begin n_err++; $display("FAIL drop_nowrite: got %b exp 0000", port_ready); end
        pkt = {8'h03, 8'h02, 8'h01, 8'hB5};
        e = pkt;
        send_pkt(pkt, to);
        reg_rd(DROP_A);
        n_cmp++; if (mem_rd_data !== 8'h01) begin n_err++; $display("FAIL drop_cnt1: got %h exp 01", mem_rd_data); end
        n_cmp++; if (port_ready !== 4'b1000 || to != 0) begin n_err++; $display("FAIL drop_next_ready: got %b exp 1000", port_ready); end
        foreach (e[k]) begin
            n_cmp++; if (port_out[3*W +: W] !== e[k]) begin n_err++; $display("FAIL drop_next%0d: got %h exp %h", k, port_out[3*W +: W], e[k]); end
            cycle(1'b0, '0, 4'b1000, 1'b0, 1'b0, '0, '0, io, ie);
        end
        reg_wr(DROP_A, 8'h00);
        reg_rd(DROP_A);
        n_cmp++; if (mem_rd_data !== 8'h00) begin n_err++; $display("FAIL drop_clear: got %h exp 00", mem_rd_data); end
        // two drops, then a clear landing on a third drop's DA
        pkt = {8'h77, 8'h00, 8'h00};
        send_pkt(pkt, to);
        send_pkt(pkt, to);
        cycle(1'b1, 8'h77, '0, 1'b1, 1'b1, DROP_A, 8'h00, io, ie);
        cycle(1'b1, 8'h00, '0, 1'b0, 1'b0, '0, '0, io, ie);
        cycle(1'b1, 8'h00, '0, 1'b0, 1'b0, '0, '0, io, ie);
        reg_rd(DROP_A);
        n_cmp++; if (mem_rd_data !== 8'h01) begin n_err++; $display("FAIL drop_collide: got %h exp 01", mem_rd_data); end
        // saturation
        for (int k = 0; k < 260; k++) send_pkt(pkt, to);
        reg_rd(DROP_A);
        n_cmp++; if (mem_rd_data !== 8'hFF) begin n_err++; $display("FAIL drop_sat: got %h exp ff", mem_rd_data); end
        reg_wr(DROP_A, 8'h00);
    endtask

    task automatic test_random();
        wq_t cur;
        logic io, ie, v, sel, wr;
        logic [NP-1:0] rd;
        logic [W-1:0] a, wd, da;
        for (int c = 0; c < 2000; c++) begin
            if (cur.size() == 0) begin
                int len, idx;
                idx = $urandom_range(0, 6);
                da = (idx == 6) ? 8'hFF : 8'(idx);
                len = $urandom_range(0, 4);
                cur.push_back(da);
                cur.push_back(8'($urandom));
                cur.push_back(8'(len));
                for (int k = 0; k < len; k++) cur.push_back(8'($urandom));
            end
            v   = ($urandom_range(0, 9) < 8);
            rd  = NP'($urandom);
            sel = ($urandom_range(0, 14) == 0);
            wr  = 1'($urandom);
            a   = 8'($urandom_range(0, NP + 2));
            wd  = (int'(a) < NP) ? 8'($urandom_range(0, 5)) : 8'($urandom);
            cycle(v, cur[0], rd, sel, wr, a, wd, io, ie);
            if (v && ie) void'(cur.pop_front());
            n_cmp++; if (io !== ie) begin n_err++; $display("FAIL rnd_in_ready c%0d: got %b exp %b", c, io, ie); end
            n_cmp++; if (port_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, port_ready, exp_ready()); end
            for (int p = 0; p < NP; p++) begin
                n_cmp++; if (port_out[p*W +: W] !== exp_out(p)) begin n_err++; $display("FAIL rnd_out c%0d p%0d: got %h exp %h", c, p, port_out[p*W +: W], exp_out(p)); end
            end
            n_cmp++; if (mem_ack !== m_ack) begin n_err++; $display("FAIL rnd_ack c%0d: got %b exp %b", c, mem_ack, m_ack); end
            if (m_rd_chk) begin
                n_cmp++; if (mem_rd_data !== m_rd) begin n_err++; $display("FAIL rnd_rd c%0d: got %h exp %h", c, mem_rd_data, m_rd); end
            end
        end
        // finish the open packet and drain
        for (int c = 0; c < 200 && cur.size() != 0; c++) begin
            cycle(1'b1, cur[0], '1, 1'b0, 1'b0, '0, '0, io, ie);
            if (ie) void'(cur.pop_front());
        end
        for (int c = 0; c < 40; c++) cycle(1'b0, '0, '1, 1'b0, 1'b0, '0, '0, io, ie);
        n_cmp++; if (port_ready !== 4'b0000 || cur.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %b exp 0000", port_ready); end
    endtask

    task automatic test_mid_reset();
        wq_t pkt, e;
        int to;
        logic io, ie;
        reg_wr(8'd0, 8'h40);
        pkt = {8'h40, 8'h01, 8'h05, 8'hD0, 8'hD1};
        send_pkt(pkt, to);
        n_cmp++; if (port_ready[0] !== 1'b1) begin n_err++; $display("FAIL mr_pre: got %b exp 1", port_ready[0]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (port_ready !== 4'b0000) begin n_err++; $display("FAIL mr_ready: got %b exp 0000", port_ready); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL mr_state: got %0d exp 0", dbg_state); end
        model_reset();
        sw_enable_in = 1'b0; port_read = '0; mem_sel_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        pkt = {8'h02, 8'h09, 8'h01, 8'hE0};
        e = pkt;
        send_pkt(pkt, to);
        n_cmp++; if (port_ready !== 4'b0100 || to != 0) begin n_err++; $display("FAIL mr_route: got %b exp 0100", port_ready); end
        foreach (e[k]) begin
            n_cmp++; if (port_out[2*W +: W] !== e[k]) begin n_err++; $display("FAIL mr_pop%0d: got %h exp %h", k, port_out[2*W +: W], e[k]); end
            cycle(1'b0, '0, 4'b0100, 1'b0, 1'b0, '0, '0, io, ie);
        end
        pkt = {8'h40, 8'h00, 8'h00};
        send_pkt(pkt, to);
        reg_rd(DROP_A);
        n_cmp++; if (mem_rd_data !== 8'h01 || port_ready !== 4'b0000) begin n_err++; $display("FAIL mr_old_addr: got drop %h ready %b exp 01 0000", mem_rd_data, port_ready); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_unicast();
        test_bcast();
        test_backpressure();
        test_drop();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
